// File: rtl/conv_addr_gen.sv
// Activation-address generator for the systolic convolution array.
// This block walks a C x H x W activation frame that is stored channel-major.
// It emits one SRAM read address per beat for every K x K x C tap of every output window.
// Up to ROWS consecutive windows form one batch, with one window per PE row.
// Within a batch, the tap loop is the outer loop and the PE row is the inner loop.
//
// state | meaning
// IDLE  | waiting for start; config writes accepted
// RUN   | presenting beats, one per addr_valid & addr_ready
// DONE  | single-cycle frame-end pulse (also follows a rejected start)
module conv_addr_gen #(
  parameter int ROWS   = 16,
  parameter int K      = 3,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [DIM_W-1:0]  cfg_data,
  input  logic              start,
  output logic              busy,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [RW-1:0]     pe_row,
  output logic              batch_last,
  output logic              done,
  output logic              cfg_err
);

  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int RMW = 2 * DIM_W + 1;
  localparam logic [KW-1:0]    KMAX   = KW'(K - 1);
  localparam logic [DIM_W-1:0] KD     = DIM_W'(K);
  localparam logic [DIM_W-1:0] ONE_D  = DIM_W'(1);
  localparam logic [RMW-1:0]   ROWS_R = RMW'(ROWS);
  localparam logic [RMW-1:0]   ONE_R  = RMW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [DIM_W-1:0] c_q, c_d, w_q, w_d, h_q, h_d, s_q, s_d;
  logic [DIM_W-1:0] ow_q, ow_d;
  logic [DIM_W-1:0] ch_q, ch_d;
  logic [KW-1:0]    ky_q, ky_d, kx_q, kx_d;
  logic [RW-1:0]    r_q, r_d;
  logic [DIM_W-1:0] ox_q, ox_d, oy_q, oy_d, oxb_q, oxb_d, oyb_q, oyb_d;
  logic [RMW-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW-1:0]    pe_row_q, pe_row_d;
  logic             last_q, last_d, valid_q, valid_d, err_q, err_d;

  logic [DIM_W-1:0] s_div, ow_calc, oh_calc, adv_ox, adv_oy;
  logic [RMW-1:0]   nwin, nb_q, nb_n;
  logic             cfg_ok, last_row, last_tap, load;

  // Config shadow: a write only lands while idle, and start in the same cycle sees it
  always_comb begin
    c_d = c_q;
    w_d = w_q;
    h_d = h_q;
    s_d = s_q;
    if (cfg_we && state_q == S_IDLE) begin
      case (cfg_sel)
        2'd0:    c_d = cfg_data;
        2'd1:    w_d = cfg_data;
        2'd2:    h_d = cfg_data;
        default: s_d = cfg_data;
      endcase
    end
  end

  // Frame geometry, batch size and raster window stepping
  always_comb begin
    s_div    = (s_d == '0) ? ONE_D : s_d;
    ow_calc  = (w_d - KD) / s_div + ONE_D;
    oh_calc  = (h_d - KD) / s_div + ONE_D;
    nwin     = RMW'(ow_calc) * RMW'(oh_calc);
    cfg_ok   = (c_d != '0) && (s_d != '0) && (w_d >= KD) && (h_d >= KD);
    nb_q     = (rem_q >= ROWS_R) ? ROWS_R : rem_q;
    last_row = (RMW'(r_q) == nb_q - ONE_R);
    last_tap = (kx_q == KMAX) && (ky_q == KMAX) && (ch_q == c_d - ONE_D);
    if (ox_q == ow_q - ONE_D) begin
      adv_ox = '0;
      adv_oy = oy_q + ONE_D;
    end else begin
      adv_ox = ox_q + ONE_D;
      adv_oy = oy_q;
    end
  end

  // Next-state and next-beat computation
  always_comb begin
    state_d  = state_q;
    ow_d     = ow_q;
    ch_d     = ch_q;
    ky_d     = ky_q;
    kx_d     = kx_q;
    r_d      = r_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    oxb_d    = oxb_q;
    oyb_d    = oyb_q;
    rem_d    = rem_q;
    valid_d  = valid_q;
    err_d    = err_q;
    addr_d   = addr_q;
    pe_row_d = pe_row_q;
    last_d   = last_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = S_RUN;
            err_d   = 1'b0;
            valid_d = 1'b1;
            load    = 1'b1;
            ow_d    = ow_calc;
            rem_d   = nwin;
            ch_d    = '0;
            ky_d    = '0;
            kx_d    = '0;
            r_d     = '0;
            ox_d    = '0;
            oy_d    = '0;
            oxb_d   = '0;
            oyb_d   = '0;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (valid_q && addr_ready) begin
          load = 1'b1;
          if (!last_row) begin
            r_d  = r_q + RW'(1);
            ox_d = adv_ox;
            oy_d = adv_oy;
          end else begin
            r_d  = '0;
            ox_d = oxb_q;
            oy_d = oyb_q;
            if (kx_q != KMAX) begin
              kx_d = kx_q + KW'(1);
            end else begin
              kx_d = '0;
              if (ky_q != KMAX) begin
                ky_d = ky_q + KW'(1);
              end else begin
                ky_d = '0;
                ch_d = ch_q + ONE_D;
              end
            end
            if (last_tap) begin
              ch_d = '0;
              if (rem_q <= ROWS_R) begin
                state_d = S_DONE;
                valid_d = 1'b0;
                load    = 1'b0;
              end else begin
                // Next batch starts at the window after this batch's last row
                rem_d = rem_q - ROWS_R;
                ox_d  = adv_ox;
                oy_d  = adv_oy;
                oxb_d = adv_ox;
                oyb_d = adv_oy;
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    nb_n = (rem_d >= ROWS_R) ? ROWS_R : rem_d;
    if (load) begin
      // Wrap-around arithmetic at ADDR_W bits gives the same low bits as a wide product truncated afterwards
      addr_d = ADDR_W'(ch_d) * ADDR_W'(w_d) * ADDR_W'(h_d)
             + (ADDR_W'(oy_d) * ADDR_W'(s_d) + ADDR_W'(ky_d)) * ADDR_W'(w_d)
             + ADDR_W'(ox_d) * ADDR_W'(s_d) + ADDR_W'(kx_d);
      pe_row_d = r_d;
      last_d   = (ch_d == c_d - ONE_D) && (ky_d == KMAX) && (kx_d == KMAX)
               && (RMW'(r_d) == nb_n - ONE_R);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      s_q      <= '0;
      ow_q     <= '0;
      ch_q     <= '0;
      ky_q     <= '0;
      kx_q     <= '0;
      r_q      <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      oxb_q    <= '0;
      oyb_q    <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      pe_row_q <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      w_q      <= w_d;
      h_q      <= h_d;
      s_q      <= s_d;
      ow_q     <= ow_d;
      ch_q     <= ch_d;
      ky_q     <= ky_d;
      kx_q     <= kx_d;
      r_q      <= r_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      oxb_q    <= oxb_d;
      oyb_q    <= oyb_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      pe_row_q <= pe_row_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign pe_row     = pe_row_q;
  assign batch_last = last_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_conv_addr_gen.sv
// Scoreboard bench for conv_addr_gen (ROWS=16, K=3, ADDR_W=16, DIM_W=8).
module tb_conv_addr_gen;
  localparam int ROWS = 16;
  localparam int KK   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [7:0]  cfg_data = '0;
  logic        start = 1'b0;
  logic        busy, addr_valid, batch_last, done, cfg_err;
  logic        addr_ready;
  logic [15:0] addr;
  logic [3:0]  pe_row;

  conv_addr_gen #(.ROWS(ROWS), .K(KK), .ADDR_W(16), .DIM_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .start(start), .busy(busy), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .pe_row(pe_row), .batch_last(batch_last), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    int          row;
    bit          last;
    bit          fin;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] act_addr[$];
  int          act_row[$];
  bit          act_last[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          rdy_mode = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enumerate batches, taps and rows directly from the frame geometry
  task automatic build_model(input int c, input int w, input int h, input int s, output int nbeats);
    int ow, oh, nwin, nbat, nb, n, ox, oy;
    beat_t e;
    ow = (w - KK) / s + 1;
    oh = (h - KK) / s + 1;
    nwin = ow * oh;
    nbat = (nwin + ROWS - 1) / ROWS;
    nbeats = 0;
    for (int b = 0; b < nbat; b++) begin
      nb = (nwin - b * ROWS < ROWS) ? nwin - b * ROWS : ROWS;
      for (int ci = 0; ci < c; ci++)
        for (int ky = 0; ky < KK; ky++)
          for (int kx = 0; kx < KK; kx++)
            for (int r = 0; r < nb; r++) begin
              n = b * ROWS + r;
              ox = n % ow;
              oy = n / ow;
              e.a = 16'((ci * w * h + (oy * s + ky) * w + ox * s + kx) & 32'hFFFF);
              e.row = r;
              e.last = (ci == c - 1) && (ky == KK - 1) && (kx == KK - 1) && (r == nb - 1);
              e.fin = e.last && (b == nbat - 1);
              exp_q.push_back(e);
              nbeats++;
            end
    end
  endtask

  // Ready driver: always, random, or a single 5-cycle drop after 10 beats
  initial begin
    int  low_left;
    bit  dropped;
    addr_ready = 1'b0;
    low_left = 0;
    dropped = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != 2) dropped = 1'b0;
      case (rdy_mode)
        0: addr_ready = 1'b1;
        1: addr_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!dropped && act_addr.size() >= 10) begin
            dropped = 1'b1;
            low_left = 5;
          end
          if (low_left > 0) begin
            addr_ready = 1'b0;
            low_left--;
          end else begin
            addr_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: compares handshaken beats against the scoreboard, hold stability and done timing
  initial begin
    bit          held, chk_done;
    logic [15:0] h_addr;
    logic [3:0]  h_row;
    logic        h_last;
    beat_t       e;
    held = 1'b0;
    chk_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        held = 1'b0;
        chk_done = 1'b0;
      end else begin
        if (chk_done) begin
          chk("done_after_last", {done, addr_valid}, 2'b10);
          chk_done = 1'b0;
        end
        if (held) begin
          chk("hold_valid", addr_valid, 1);
          chk("hold_addr", addr, h_addr);
          chk("hold_row", pe_row, h_row);
          chk("hold_last", batch_last, h_last);
          held = 1'b0;
        end
        if (addr_valid && addr_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got addr %0d expected no beat", addr);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", addr, e.a);
            chk("beat_row", pe_row, e.row);
            chk("beat_last", batch_last, e.last);
            if (e.fin) chk_done = 1'b1;
          end
          act_addr.push_back(addr);
          act_row.push_back(int'(pe_row));
          act_last.push_back(batch_last);
        end else if (addr_valid) begin
          held = 1'b1;
          h_addr = addr;
          h_row = pe_row;
          h_last = batch_last;
        end
      end
    end
  end

  task automatic wr(input logic [1:0] sel, input int d);
    @(posedge clk);
    #1;
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_data = 8'(d);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int cnt = 0;
    while (!done && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
  endtask

  // Runs one legal frame; with coincide set, W is written in the start cycle
  task automatic run_frame(input int c, input int w, input int h, input int s, input bit coincide);
    int nb;
    wr(2'd0, c);
    if (!coincide) wr(2'd1, w);
    wr(2'd2, h);
    wr(2'd3, s);
    act_addr.delete();
    act_row.delete();
    act_last.delete();
    build_model(c, w, h, s, nb);
    @(posedge clk);
    #1;
    start = 1'b1;
    if (coincide) begin
      cfg_we = 1'b1;
      cfg_sel = 2'd1;
      cfg_data = 8'(w);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_we = 1'b0;
    chk("start_valid_busy", {addr_valid, busy, cfg_err}, 3'b110);
    wait_done(nb * 8 + 50);
    chk("frame_beats", act_addr.size(), nb);
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("busy_fall", busy, 0);
  endtask

  task automatic reject_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("reject_err_done", {cfg_err, done, addr_valid}, 3'b110);
    repeat (3) @(negedge clk);
    chk("reject_no_valid", addr_valid, 0);
    chk("reject_err_sticky", cfg_err, 1);
  endtask

  int exp_a8[8] = '{0, 1, 4, 5, 1, 2, 5, 6};
  int exp_b4[4] = '{0, 2, 10, 12};

  initial begin
    int nlast, nb;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {busy, addr_valid, addr, pe_row, batch_last, done, cfg_err}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outputs", {busy, addr_valid, addr, pe_row, batch_last, done, cfg_err}, 0);
    mon_en = 1'b1;

    rdy_mode = 0;
    run_frame(1, 4, 4, 1, 1'b0);
    for (int i = 0; i < 8; i++) chk("a_first8", act_addr[i], exp_a8[i]);
    chk("a_last_addr", act_addr[35], 15);
    chk("a_last_flag", act_last[35], 1);

    run_frame(1, 5, 5, 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("b_first4", act_addr[i], exp_b4[i]);
      chk("b_row", act_row[i], i);
    end
    chk("b_last_addr", act_addr[35], 24);

    run_frame(2, 7, 7, 1, 1'b0);
    nlast = 0;
    foreach (act_last[i]) if (act_last[i]) nlast++;
    chk("c_batch_count", nlast, 2);

    rdy_mode = 2;
    run_frame(2, 4, 4, 1, 1'b0);
    rdy_mode = 0;

    wr(2'd1, 2);
    reject_start();
    run_frame(1, 4, 4, 1, 1'b1);
    chk("err_cleared", cfg_err, 0);

    rdy_mode = 1;
    for (int i = 0; i < 10; i++)
      run_frame($urandom_range(1, 2), $urandom_range(3, 8), $urandom_range(3, 8),
                $urandom_range(1, 3), 1'b0);
    rdy_mode = 0;

    wr(2'd0, 2);
    wr(2'd1, 6);
    wr(2'd2, 6);
    wr(2'd3, 1);
    act_addr.delete();
    build_model(2, 6, 6, 1, nb);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 200 && act_addr.size() < 20; i++) @(negedge clk);
    chk("mid_frame_busy", busy, 1);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {busy, addr_valid, addr, pe_row, batch_last, done, cfg_err}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    reject_start();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
